exp_softmax_norm: RTL and testbench
===================================

// Module: exp_softmax_norm
// PURPOSE
//  Downstream consumer of the combinational exp(-x) Taylor stage (Q.7, 128 = 1.0).
//  Buffers one frame of exp values, accumulates their sum, then emits each value
//  divided by the sum as an 8-bit Q1.7 probability (softmax normalisation).
//  Sequential shift-subtract divider; valid/ready on both sides.
// PARAMETERS
//  DEPTH  16         max elements per frame (power of 2)
//  DW     16         input exp value width (unsigned, Q.7)
//  SUM_W  DW+4       accumulator width, DW+log2(DEPTH); never overflows
//  FRAC   7          output fractional bits
//  OW     8          output width, FRAC+1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  in_valid   in   1      input element valid
//  in_ready   out  1      block accepts input
//  in_data    in   DW     exp value, unsigned, 128 = 1.0
//  in_last    in   1      marks final element of frame
//  out_valid  out  1      normalised element valid
//  out_ready  in   1      sink accepts output
//  out_data   out  OW     in_data*2^FRAC/sum, truncated, 128 = 1.0
//  out_last   out  1      final element of frame
//  busy       out  1      high in DIVIDE or EMIT
//  ovf        out  1      sticky: frame force-closed at DEPTH; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=COLLECT, counters/sum=0, out_valid=0,
//   out_data=0, out_last=0, ovf=0, busy=0; in_ready=1 after release. Buffer
//   contents don't-care. Reset mid-frame discards the partial frame; out_valid
//   falls immediately.
//  States COLLECT -> DIVIDE -> EMIT -> (DIVIDE | COLLECT).
//  COLLECT: in_ready=1. Handshake = in_valid & in_ready. Each handshake writes
//   buf[wr_cnt]=in_data, sum+=in_data, wr_cnt++. Frame closes on handshake with
//   in_last=1, or on the DEPTH-th handshake. n = wr_cnt+1. Next state DIVIDE, rd_idx=0.
//   Closing on DEPTH without in_last sets ovf. The next input starts a new frame.
//   in_last on the DEPTH-th element is a normal close; ovf unchanged.
//  DIVIDE: in_ready=0. Numerator = buf[rd_idx] << FRAC (DW+FRAC bits), divisor = sum.
//   Restoring division, one quotient bit per cycle, MSB first, exactly OW cycles.
//   Quotient <= 2^FRAC always, so it fits OW bits; no saturation needed.
//   sum==0: quotient forced to 0; no divide performed, same cycle count.
//  EMIT: out_valid=1, out_data=quotient, out_last=(rd_idx==n-1).
//   Outputs are held stable while out_ready=0.
//   On out_valid & out_ready: if last, clear sum/wr_cnt and go to COLLECT
//   (in_ready=1 next cycle); otherwise rd_idx++ and go to DIVIDE.
//  Latency: first out_valid at OW+1 cycles after the closing handshake.
//   With out_ready held high, each element takes OW+1 cycles.
//  No input is accepted during DIVIDE/EMIT; upstream must stall.
//  busy = (state != COLLECT).
// TESTING
//  T1 frame {128,384}, last on 2nd -> out 32, 96; out_last on 96; ovf=0
//  T2 single {50} with in_last -> out 128, out_last=1, back in COLLECT, in_ready=1
//  T3 frame {0,0,0} -> out 0,0,0 with no X; out_last on 3rd
//  T4 {128,128,128,128}, out_ready low 5 cycles on 2nd output -> out_data holds 32,
//     all four 32s delivered, in_ready=0 throughout
//  T5 17 inputs of 64, no in_last -> 16 outputs of 8, ovf=1,
//     17th forms a new frame -> single output 128
//  T6 assert rst_n=0 during EMIT -> out_valid=0 asynchronously, ovf=0;
//     after release in_ready=1 and a new frame {10,30} -> 32, 96

Source files
------------

// File: rtl/exp_softmax_norm.sv
// Softmax normaliser: buffers one frame of Q.7 exp values, sums them, then emits
// each value divided by the frame sum as a Q1.7 probability using a restoring divider.
module exp_softmax_norm #(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int SUM_W = DW + $clog2(DEPTH),
    parameter int FRAC  = 7,
    parameter int OW    = FRAC + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(OW);

    typedef enum logic [1:0] {
        COLLECT,
        DIVIDE,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_cnt;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    last_idx;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] rem;
    logic [BW-1:0]    bit_cnt;
    logic [OW-1:0]    quot;

    logic             in_hs;
    logic             out_hs;
    logic             frame_full;
    logic             close_frame;
    logic             is_last;
    logic [DW-1:0]    cur;
    logic [SUM_W-1:0] src;
    logic             shift_bit;
    logic [SUM_W:0]   trial;
    logic [SUM_W:0]   diff;
    logic             ge;
    logic [SUM_W-1:0] rem_nxt;
    logic             q_bit;

    assign in_ready    = (state == COLLECT);
    assign busy        = (state != COLLECT);
    assign out_valid   = (state == EMIT);
    assign out_data    = quot;
    assign is_last     = (rd_idx == last_idx);
    assign out_last    = out_valid & is_last;
    assign in_hs       = in_valid & in_ready;
    assign out_hs      = out_valid & out_ready;
    assign frame_full  = (wr_cnt == AW'(DEPTH - 1));
    assign close_frame = in_hs & (in_last | frame_full);

    // Numerator is cur << FRAC with OW == FRAC+1: the first step starts from cur >> 1
    // (always below sum) and shifts in cur[0]; later steps shift in zeros.
    assign cur       = mem[rd_idx];
    assign src       = (bit_cnt == '0) ? SUM_W'(cur >> 1) : rem;
    assign shift_bit = (bit_cnt == '0) ? cur[0] : 1'b0;
    assign trial     = {src, shift_bit};
    assign diff      = trial - {1'b0, sum};
    assign ge        = ~diff[SUM_W];
    assign rem_nxt   = ge ? diff[SUM_W-1:0] : trial[SUM_W-1:0];
    assign q_bit     = ge & (sum != '0);

    // Frame storage carries no reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[wr_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (close_frame) state_nxt = DIVIDE;
            DIVIDE:  if (bit_cnt == BW'(OW - 1)) state_nxt = EMIT;
            EMIT:    if (out_hs) state_nxt = is_last ? COLLECT : DIVIDE;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt   <= '0;
            rd_idx   <= '0;
            last_idx <= '0;
            sum      <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            quot     <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_hs) begin
                        sum    <= sum + SUM_W'(in_data);
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                    if (close_frame) begin
                        last_idx <= wr_cnt;
                        rd_idx   <= '0;
                        bit_cnt  <= '0;
                        if (frame_full && !in_last) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    rem     <= rem_nxt;
                    quot    <= {quot[OW-2:0], q_bit};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                EMIT: begin
                    if (out_hs) begin
                        bit_cnt <= '0;
                        if (is_last) begin
                            sum    <= '0;
                            wr_cnt <= '0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_softmax_norm.sv
// Directed bench for exp_softmax_norm: table of frames plus hand sequences for
// backpressure, overflow force-close and asynchronous reset mid-emit.
module tb_exp_softmax_norm;

    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int OW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                        len;
        logic [DEPTH-1:0][DW-1:0]  din;
        logic [DEPTH-1:0][OW-1:0]  expv;
    } vec_t;

    vec_t vecs [4];
    logic [DEPTH-1:0][DW-1:0] hdin;
    logic [DEPTH-1:0][OW-1:0] hexp;

    exp_softmax_norm #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge following the closing handshake.
    task automatic apply_stimulus(input int len, input logic [DEPTH-1:0][DW-1:0] din, input bit use_last);
        int waited;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = din[i];
            in_last  = use_last && (i == len - 1);
            waited = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                check_output("in_ready timeout", 0, 1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (use_last || len == DEPTH) begin
            check_output("busy after close", busy, 1);
            check_output("in_ready after close", in_ready, 0);
        end
    endtask

    task automatic recv_frame(input string tag, input int len, input logic [DEPTH-1:0][OW-1:0] expv,
                              input int stall_idx, input int stall_cyc);
        int waited;
        for (int i = 0; i < len; i++) begin
            out_ready = (i != stall_idx);
            waited = 0;
            while (!out_valid && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (!out_valid) begin
                check_output({tag, " out_valid timeout"}, 0, 1);
                out_ready = 1'b0;
                return;
            end
            if (i == stall_idx) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    check_output({tag, " stall out_data"}, out_data, expv[i]);
                    check_output({tag, " stall out_valid"}, out_valid, 1);
                    check_output({tag, " stall in_ready"}, in_ready, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check_output({tag, " out_data"}, out_data, expv[i]);
            check_output({tag, " out_last"}, out_last, (i == len - 1) ? 1 : 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_output({tag, " in_ready after frame"}, in_ready, 1);
        check_output({tag, " busy after frame"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int waited;

        for (int k = 0; k < 4; k++) begin
            vecs[k].len  = 0;
            vecs[k].din  = '0;
            vecs[k].expv = '0;
        end
        vecs[0].len = 2;
        vecs[0].din[0] = 16'd128; vecs[0].din[1] = 16'd384;
        vecs[0].expv[0] = 8'd32;  vecs[0].expv[1] = 8'd96;
        vecs[1].len = 1;
        vecs[1].din[0] = 16'd50;
        vecs[1].expv[0] = 8'd128;
        vecs[2].len = 3;
        vecs[3].len = 3;
        vecs[3].din[0] = 16'd100; vecs[3].din[1] = 16'd200; vecs[3].din[2] = 16'd300;
        vecs[3].expv[0] = 8'd21;  vecs[3].expv[1] = 8'd42;  vecs[3].expv[2] = 8'd64;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset out_valid", out_valid, 0);
        check_output("reset out_data", out_data, 0);
        check_output("reset out_last", out_last, 0);
        check_output("reset busy", busy, 0);
        check_output("reset ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("in_ready after reset", in_ready, 1);

        for (int k = 0; k < 4; k++) begin
            apply_stimulus(vecs[k].len, vecs[k].din, 1'b1);
            recv_frame($sformatf("vec%0d", k), vecs[k].len, vecs[k].expv, -1, 0);
            check_output($sformatf("vec%0d ovf", k), ovf, 0);
        end

        // Backpressure on the second element of four equal values
        hdin = '0; hexp = '0;
        for (int i = 0; i < 4; i++) begin
            hdin[i] = 16'd128;
            hexp[i] = 8'd32;
        end
        apply_stimulus(4, hdin, 1'b1);
        recv_frame("stall", 4, hexp, 1, 5);

        // Seventeen inputs without in_last: first sixteen force-close with ovf
        hdin = '0; hexp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hdin[i] = 16'd64;
            hexp[i] = 8'd8;
        end
        apply_stimulus(DEPTH, hdin, 1'b0);
        check_output("ovf after force close", ovf, 1);
        recv_frame("ovf16", DEPTH, hexp, -1, 0);
        hexp[0] = 8'd128;
        apply_stimulus(1, hdin, 1'b1);
        recv_frame("ovf17", 1, hexp, -1, 0);
        check_output("ovf sticky", ovf, 1);

        // Asynchronous reset while an output is waiting
        hdin = '0;
        hdin[0] = 16'd128; hdin[1] = 16'd384;
        apply_stimulus(2, hdin, 1'b1);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_output("emit before reset", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_output("async reset out_valid", out_valid, 0);
        check_output("async reset ovf", ovf, 0);
        check_output("async reset busy", busy, 0);
        check_output("async reset out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("in_ready after mid reset", in_ready, 1);
        hdin = '0; hexp = '0;
        hdin[0] = 16'd10; hdin[1] = 16'd30;
        hexp[0] = 8'd32;  hexp[1] = 8'd96;
        apply_stimulus(2, hdin, 1'b1);
        recv_frame("post reset", 2, hexp, -1, 0);

        // in_last on the sixteenth element is a normal close
        hdin = '0; hexp = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hdin[i] = 16'd128;
            hexp[i] = 8'd8;
        end
        apply_stimulus(DEPTH, hdin, 1'b1);
        check_output("full frame with last ovf", ovf, 0);
        recv_frame("full16", DEPTH, hexp, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
